// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring unsigned divider, one bit per cycle.
// The first step runs on the start edge so the last result lands WIDTH-1 edges later.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] acc_s, x_s, y_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, div_q, div_d, div_s;
  logic [WIDTH:0]   part_c, trial_c;

  // acc: product accumulator or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
  always_comb begin
    acc_s  = start_i ? '0 : acc_q;
    x_s    = start_i ? a_i : x_q;
    y_s    = start_i ? b_i : y_q;
    div_s  = start_i ? is_div_i : div_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    done_d = 1'b0;
    part_c  = {acc_s, x_s[WIDTH-1]};
    trial_c = part_c - {1'b0, y_s};
    if (start_i || busy_q) begin
      div_d = div_s;
      if (div_s) begin
        if (!trial_c[WIDTH]) begin
          acc_d = trial_c[WIDTH-1:0];
          x_d   = {x_s[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = part_c[WIDTH-1:0];
          x_d   = {x_s[WIDTH-2:0], 1'b0};
        end
        y_d = y_s;
      end else begin
        acc_d = acc_s + (y_s[0] ? x_s : '0);
        x_d   = x_s << 1;
        y_d   = y_s >> 1;
      end
      if (start_i) begin
        cnt_d  = CW'(1);
        busy_d = 1'b1;
      end else if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      div_q  <= div_d;
    end
  end

  assign done_o      = done_q;
  assign product_o   = acc_q;
  assign quotient_o  = x_q;
  assign remainder_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops registered on accept, mul/div stall via in_ready
// while the iterative unit runs. Result and flags hold until out_valid && out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dbz_q, dbz_d, rem_q, rem_d;
  logic             accept_c, start_c, op_div_c, op_iter_c, mdone_c;
  logic [WIDTH-1:0] prod_c, quot_c, remd_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_carry_c, alu_ovf_c, alu_dbz_c, big_shift_c;
  logic [WIDTH:0]   sum_c, diff_c;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c = in_valid && in_ready;
  assign op_div_c  = (op == OP_DIVU) || (op == OP_REMU);
  assign op_iter_c = (op == OP_MUL) || (op_div_c && (b != '0));

  // Single-cycle results; divu/remu entries only matter for the b == 0 case
  always_comb begin
    sum_c       = {1'b0, a} + {1'b0, b};
    diff_c      = {1'b0, a} - {1'b0, b};
    big_shift_c = (a >= WIDTH'(WIDTH));
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    alu_dbz_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c   = diff_c[WIDTH-1:0];
        alu_carry_c = diff_c[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res_c = big_shift_c ? '0 : (b << a[SHW-1:0]);
      OP_AND:  alu_res_c = a & b;
      OP_OR:   alu_res_c = a | b;
      OP_XOR:  alu_res_c = a ^ b;
      OP_SRL:  alu_res_c = big_shift_c ? '0 : (b >> a[SHW-1:0]);
      OP_SRA:  alu_res_c = big_shift_c ? {WIDTH{b[WIDTH-1]}} : WIDTH'($signed(b) >>> a[SHW-1:0]);
      OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_DIVU: begin
        alu_res_c = '1;
        alu_dbz_c = 1'b1;
      end
      OP_REMU: begin
        alu_res_c = a;
        alu_dbz_c = 1'b1;
      end
      default: alu_res_c = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    rem_d    = rem_q;
    start_c  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept_c) begin
          if (op_iter_c) begin
            start_c = 1'b1;
            rem_d   = (op == OP_REMU);
            state_d = (op == OP_MUL) ? MUL : DIV;
          end else begin
            state_d  = DONE;
            result_d = alu_res_c;
            zero_d   = (alu_res_c == '0);
            carry_d  = alu_carry_c;
            ovf_d    = alu_ovf_c;
            dbz_d    = alu_dbz_c;
          end
        end
      end
      MUL, DIV: begin
        if (mdone_c) begin
          state_d  = DONE;
          result_d = (state_q == MUL) ? prod_c : (rem_q ? remd_c : quot_c);
          zero_d   = (result_d == '0);
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      rem_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      rem_q    <= rem_d;
    end
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_c),
    .is_div_i    (op_div_c),
    .a_i         (a),
    .b_i         (b),
    .done_o      (mdone_c),
    .product_o   (prod_c),
    .quotient_o  (quot_c),
    .remainder_o (remd_c)
  );

  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit combinational datapath ALU.
- Adds right shifts, set-less-than, status flags, and iterative multiply and unsigned divide/remainder.
- Sits between decode/register-read and writeback.
- Single-cycle ops complete in 1 cycle; mul/div stall the pipeline through valid/ready.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4, power of 2).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an op this cycle
- a  in  WIDTH  operand A (shift amount for shifts)
- b  in  WIDTH  operand B (value shifted for shifts)
- op  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  add carry-out / sub borrow
- overflow  out  1  signed overflow (add/sub)
- div_by_zero  out  1  divu/remu with b == 0

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE; out_valid=0, result=0, zero=0, carry=0, overflow=0, div_by_zero=0. Applies mid-operation; an in-flight mul/div is discarded.
- Opcodes:
  - 0000 add, 0001 sub (a-b), 0010 sll (b<<a), 0011 and, 0100 or, 0101 xor
  - 0110 srl (b>>a), 0111 sra (b>>>a), 1000 slt signed, 1001 sltu
  - 1010 mul (low WIDTH bits of a*b), 1100 divu (a/b), 1101 remu (a%b)
  - 1011/1110/1111: result 0
- Shifts: amount is the full a. If a ≥ WIDTH: sll/srl give 0, sra gives all copies of b[WIDTH-1].
- slt/sltu: result is 1 or 0, zero-extended.
- Flags:
  - carry: add = carry-out; sub = 1 when a<b unsigned (borrow).
  - overflow: signed overflow for add/sub only.
  - carry and overflow are 0 for all other ops.
  - zero reflects the final result for every op, including illegal opcodes (zero=1).
- Handshake:
  - Accept when in_valid && in_ready. Inputs are captured at that edge; later changes are ignored.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Holding: out_valid stays high, and result/flags stay stable, until out_valid && out_ready.
- State machine:
  - IDLE: on accept, single-cycle op → DONE at next edge with result registered.
  - IDLE: on accept, mul → MUL; divu/remu with b≠0 → DIV; divu/remu with b==0 → DONE.
  - MUL: shift-add, one bit per cycle, WIDTH cycles, then DONE.
  - DIV: restoring division, one bit per cycle, WIDTH cycles, then DONE.
  - DONE: out_valid=1. On out_ready, either accept a new op in the same cycle (state set per IDLE rules) or return to IDLE.
- Latency (accept edge to out_valid high):
  - single-cycle ops: 1 cycle
  - mul, divu/remu: WIDTH+1 cycles
  - divide-by-zero: 1 cycle
- Divide by zero: divu gives all ones; remu gives a; div_by_zero=1. div_by_zero is 0 otherwise.
- Throughput: back-to-back single-cycle ops sustain 1 per cycle while out_ready=1.
- in_valid is ignored when in_ready=0; no op is dropped or duplicated.

Decomposition:
- alu_pkg holds: opcode localparams (OP_ADD … OP_REMU), state enum (IDLE, MUL, DIV, DONE).
- Sub-module alu_iter_muldiv holds the iterative mul/div datapath.
  - Inputs: start, is_div, a, b.
  - Outputs: done pulse, product/quotient/remainder.
  - Shares clk/rst_n.
- Top level keeps the FSM, single-cycle ops, flags and handshake.

Test Plan:
- WIDTH=16, out_ready=1, consecutive add 0x7FFF+0x0001, sub 0x0003-0x0005, xor 0xFFFF^0xFFFF:
  - results 0x8000 (ovf=1, carry=0), 0xFFFE (carry=1, ovf=0), 0x0000 (zero=1).
  - out_valid each cycle; 1-cycle latency.
- Shifts:
  - sll a=4, b=0x0123 → 0x1230
  - sra a=20, b=0x8000 → 0xFFFF
  - srl a=16, b=0xFFFF → 0x0000
  - slt a=0xFFFF, b=0x0001 → 1; sltu same operands → 0
- mul a=0x0123, b=0x0045 → result 0x4E6F. out_valid exactly 17 cycles after accept; in_ready=0 throughout.
- divu a=1000, b=7 → 142; remu same operands → 6; each 17-cycle latency. divu a=5, b=0 → 0xFFFF, div_by_zero=1, 1-cycle latency.
- Backpressure: out_ready=0 for 5 cycles after an add completes → result/flags stable, in_ready=0, second in_valid not accepted until out_ready=1.
- Reset: rst_n low for 1 edge at cycle 8 of a mul → all outputs 0, state IDLE. Next op add 2+2 → 4 with normal latency.
